// File: rtl/pgr_uart_rx_word_32bit.sv
// UART 8N1 receiver with 3-sample majority vote per bit.
// Packs four bytes little-endian into a 32-bit word with valid/ready.
module pgr_uart_rx_word_32bit #(
   parameter int OVERSAMPLE  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        rxd,
   output logic [31:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        frame_err,
   output logic        overrun,
   output logic        busy
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BRK   = 3'd4;

   localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] OS_S1   = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] OS_S2   = 4'(OVERSAMPLE / 2);
   localparam logic [3:0] OS_S3   = 4'(OVERSAMPLE / 2 + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [2:0]  state_q, state_d;
   logic [3:0]  os_q, os_d;
   logic [3:0]  os_nxt;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  samp_q, samp_d;
   logic [31:0] asm_q, asm_d;
   logic [1:0]  idx_q, idx_d;
   logic        cmpl_q, cmpl_d;
   logic        ferr_q, ferr_d;
   logic        ovr_q, ovr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wvalid_q, wvalid_d;
   logic        rxd_s;
   logic        vote_full;
   logic        vote_mid;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign rxd_s     = sync_q[SYNC_STAGES-1];
   assign vote_full = maj3(samp_q[2], samp_q[1], samp_q[0]);
   // Stop is decided on its last sample tick, so that sample is taken live.
   assign vote_mid  = maj3(samp_q[1], samp_q[0], rxd_s);
   assign os_nxt    = (os_q == OS_LAST) ? 4'd0 : os_q + 4'd1;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], rxd};
      state_d  = state_q;
      os_d     = os_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      samp_d   = samp_q;
      asm_d    = asm_q;
      idx_d    = idx_q;
      cmpl_d   = 1'b0;
      ferr_d   = 1'b0;
      ovr_d    = 1'b0;
      wdata_d  = wdata_q;
      wvalid_d = wvalid_q;

      if (clk_en) begin
         if (os_q == OS_S1 || os_q == OS_S2 || os_q == OS_S3) begin
            samp_d = {samp_q[1:0], rxd_s};
         end
         unique case (state_q)
            ST_IDLE: begin
               os_d = 4'd0;
               if (!rxd_s) begin
                  state_d = ST_START;
                  os_d    = 4'd1;
               end
            end
            ST_START: begin
               os_d = os_nxt;
               if (os_q == OS_LAST) begin
                  bit_d   = 3'd0;
                  state_d = vote_full ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               os_d = os_nxt;
               if (os_q == OS_LAST) begin
                  shreg_d = {vote_full, shreg_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = ST_STOP;
               end
            end
            ST_STOP: begin
               os_d = os_nxt;
               if (os_q == OS_S3) begin
                  os_d = 4'd0;
                  if (vote_mid) begin
                     state_d = ST_IDLE;
                     asm_d[{idx_q, 3'b000} +: 8] = shreg_q;
                     idx_d  = idx_q + 2'd1;
                     cmpl_d = (idx_q == 2'd3);
                  end else begin
                     state_d = ST_BRK;
                     ferr_d  = 1'b1;
                     idx_d   = 2'd0;
                  end
               end
            end
            ST_BRK: begin
               os_d = 4'd0;
               if (rxd_s) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               os_d    = 4'd0;
            end
         endcase
      end

      if (cmpl_q) begin
         if (!wvalid_q || word_ready) begin
            wdata_d  = asm_q;
            wvalid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (wvalid_q && word_ready) begin
         wvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '1;
         state_q  <= ST_IDLE;
         os_q     <= 4'd0;
         bit_q    <= 3'd0;
         shreg_q  <= 8'd0;
         samp_q   <= 3'b111;
         asm_q    <= 32'd0;
         idx_q    <= 2'd0;
         cmpl_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         wdata_q  <= 32'd0;
         wvalid_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         os_q     <= os_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         samp_q   <= samp_d;
         asm_q    <= asm_d;
         idx_q    <= idx_d;
         cmpl_q   <= cmpl_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
         wdata_q  <= wdata_d;
         wvalid_q <= wvalid_d;
      end
   end

   assign word_data  = wdata_q;
   assign word_valid = wvalid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
